dma_xform_pipe: RTL and testbench

Parametrised successor to the loopback AFU datapath: a pipelined, elastic transform engine between the DMA read stream and the DMA write stream. It accepts a job (`go`, `size`, `mode`, `operand`) from the memory map, pulls exactly `size` cache lines from the read FIFO, and applies a per-lane transform in a 2-stage pipeline. It pushes the results to the write side with full backpressure, and reports `done` only after the DMA write engine confirms completion.

---
 rtl/dma_xform_pkg.sv | 24 ++
 rtl/dma_xform_lane.sv | 40 ++++
 rtl/dma_xform_pipe.sv | 149 ++++++++++++++
 tb/tb_dma_xform_pipe.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dma_xform_pkg.sv
// dma_xform_pkg
// Shared types and constants for the DMA transform pipeline.
//   mode_t             : per-lane transform selector (PASS, ADD, XOR, BSWAP)
//   state_t            : job control FSM states
//   CL_BYTE_INDEX_BITS : log2 of the cache-line size in bytes
package dma_xform_pkg;

  localparam int CL_BYTE_INDEX_BITS = 6;

  typedef enum logic [1:0] {
    PASS  = 2'd0,
    ADD   = 2'd1,
    XOR   = 2'd2,
    BSWAP = 2'd3
  } mode_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    WAIT_WR = 2'd2,
    DONE    = 2'd3
  } state_t;

endpackage

// File: rtl/dma_xform_lane.sv
// dma_xform_lane
// Combinational transform of a single LANE_WIDTH-bit lane.
// Ports:
//   mode    : transform select (PASS, ADD, XOR, BSWAP)
//   operand : constant for ADD / XOR
//   din     : lane input
//   dout    : transformed lane
module dma_xform_lane
  import dma_xform_pkg::*;
#(
  parameter int LANE_WIDTH = 32
) (
  input  mode_t                 mode,
  input  logic [LANE_WIDTH-1:0] operand,
  input  logic [LANE_WIDTH-1:0] din,
  output logic [LANE_WIDTH-1:0] dout
);

  localparam int NUM_BYTES = LANE_WIDTH / 8;

  logic [LANE_WIDTH-1:0] swapped;

  // Byte i of the result takes byte (NUM_BYTES-1-i) of the input.
  for (genvar gi = 0; gi < NUM_BYTES; gi++) begin : g_swap
    assign swapped[gi*8 +: 8] = din[(NUM_BYTES-1-gi)*8 +: 8];
  end

  always_comb begin
    dout = din;
    unique case (mode)
      PASS:    dout = din;
      // Sum is truncated to the lane width, so no carry leaves the lane.
      ADD:     dout = din + operand;
      XOR:     dout = din ^ operand;
      BSWAP:   dout = swapped;
      default: dout = din;
    endcase
  end

endmodule

// File: rtl/dma_xform_pipe.sv
// dma_xform_pipe
// Elastic two-stage transform engine between the DMA read FIFO and the DMA
// write FIFO. A job pulls exactly `size` lines, transforms each lane, pushes
// the results with full backpressure and reports done once the write engine
// confirms completion.
// Ports:
//   clk, rst         : clock, synchronous active-high reset
//   go               : single-cycle job start (ignored while busy)
//   size/mode/operand: job parameters, latched on an accepted go
//   rd_data/rd_empty : read FIFO head (first-word fall-through) and empty flag
//   rd_en            : pop the read FIFO head
//   wr_full          : write FIFO full
//   wr_en/wr_data    : push a transformed line
//   wr_done          : DMA write engine has completed the job
//   busy/done        : job in progress / job complete (level)
//   lines_out        : lines pushed in the current or last job
module dma_xform_pipe
  import dma_xform_pkg::*;
#(
  parameter int DATA_WIDTH = 512,
  parameter int LANE_WIDTH = 32,
  parameter int SIZE_WIDTH = 17
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  go,
  input  logic [SIZE_WIDTH-1:0] size,
  input  logic [1:0]            mode,
  input  logic [LANE_WIDTH-1:0] operand,
  input  logic [DATA_WIDTH-1:0] rd_data,
  input  logic                  rd_empty,
  output logic                  rd_en,
  input  logic                  wr_full,
  output logic                  wr_en,
  output logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_done,
  output logic                  busy,
  output logic                  done,
  output logic [SIZE_WIDTH-1:0] lines_out
);

  localparam int NUM_LANES = DATA_WIDTH / LANE_WIDTH;

  state_t                state_reg, state_next;
  logic [SIZE_WIDTH-1:0] size_reg;
  mode_t                 mode_reg;
  logic [LANE_WIDTH-1:0] operand_reg;
  logic [SIZE_WIDTH-1:0] lines_in_reg;
  logic [SIZE_WIDTH-1:0] lines_out_reg;

  logic                  s0_valid_reg;
  logic [DATA_WIDTH-1:0] s0_data_reg;
  logic                  s1_valid_reg;
  logic [DATA_WIDTH-1:0] s1_data_reg;
  logic [DATA_WIDTH-1:0] xform_data;

  logic start;
  logic s1_ready;
  logic s0_advance;
  logic s0_ready;

  // A go is only honoured when no job is in flight.
  assign start = go & ((state_reg == IDLE) | (state_reg == DONE));

  // Elastic handshakes: each stage may load when it is empty or is being
  // emptied in the same cycle.
  assign s1_ready   = !s1_valid_reg | !wr_full;
  assign s0_advance = s0_valid_reg & s1_ready;
  assign s0_ready   = !s0_valid_reg | s0_advance;

  // The lines_in gate keeps the pop count from ever exceeding size.
  assign rd_en = (state_reg == RUN) & !rd_empty & (lines_in_reg < size_reg) & s0_ready;
  assign wr_en = s1_valid_reg & !wr_full;

  assign wr_data   = s1_data_reg;
  assign busy      = (state_reg == RUN) | (state_reg == WAIT_WR);
  assign done      = (state_reg == DONE);
  assign lines_out = lines_out_reg;

  for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
    dma_xform_lane #(
      .LANE_WIDTH(LANE_WIDTH)
    ) u_lane (
      .mode   (mode_reg),
      .operand(operand_reg),
      .din    (s0_data_reg[gi*LANE_WIDTH +: LANE_WIDTH]),
      .dout   (xform_data[gi*LANE_WIDTH +: LANE_WIDTH])
    );
  end

  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      IDLE, DONE: begin
        // An empty job completes at once without waiting on the writer.
        if (go) state_next = (size == '0) ? DONE : RUN;
      end
      RUN: begin
        // Every popped line has been pushed, so the pipeline is empty.
        if (lines_out_reg == size_reg) state_next = WAIT_WR;
      end
      WAIT_WR: begin
        if (wr_done) state_next = DONE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      size_reg      <= '0;
      mode_reg      <= PASS;
      operand_reg   <= '0;
      lines_in_reg  <= '0;
      lines_out_reg <= '0;
      s0_valid_reg  <= 1'b0;
      s0_data_reg   <= '0;
      s1_valid_reg  <= 1'b0;
      s1_data_reg   <= '0;
    end else begin
      state_reg <= state_next;

      if (start) begin
        size_reg      <= size;
        mode_reg      <= mode_t'(mode);
        operand_reg   <= operand;
        lines_in_reg  <= '0;
        lines_out_reg <= '0;
      end else begin
        if (rd_en) lines_in_reg  <= lines_in_reg + SIZE_WIDTH'(1);
        if (wr_en) lines_out_reg <= lines_out_reg + SIZE_WIDTH'(1);
      end

      if (s0_ready) begin
        s0_valid_reg <= rd_en;
        if (rd_en) s0_data_reg <= rd_data;
      end

      // Data is only replaced by a valid line so wr_data stays stable
      // across bubbles and stalls.
      if (s1_ready) begin
        s1_valid_reg <= s0_valid_reg;
        if (s0_valid_reg) s1_data_reg <= xform_data;
      end
    end
  end

endmodule

// File: tb/tb_dma_xform_pipe.sv
// tb_dma_xform_pipe
// Self-checking bench for dma_xform_pipe: randomized FIFO traffic against a
// lane-by-lane reference model and an ordered scoreboard of pushed lines.
module tb_dma_xform_pipe;

  localparam int DW = 512;
  localparam int LW = 32;
  localparam int SW = 17;
  localparam int NL = DW / LW;

  logic          clk = 1'b0;
  logic          rst;
  logic          go;
  logic [SW-1:0] size;
  logic [1:0]    mode;
  logic [LW-1:0] operand;
  logic [DW-1:0] rd_data;
  logic          rd_empty;
  logic          rd_en;
  logic          wr_full;
  logic          wr_en;
  logic [DW-1:0] wr_data;
  logic          wr_done;
  logic          busy;
  logic          done;
  logic [SW-1:0] lines_out;

  dma_xform_pipe #(
    .DATA_WIDTH(DW),
    .LANE_WIDTH(LW),
    .SIZE_WIDTH(SW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .go       (go),
    .size     (size),
    .mode     (mode),
    .operand  (operand),
    .rd_data  (rd_data),
    .rd_empty (rd_empty),
    .rd_en    (rd_en),
    .wr_full  (wr_full),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .wr_done  (wr_done),
    .busy     (busy),
    .done     (done),
    .lines_out(lines_out)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  logic [DW-1:0] src_q[$];
  logic [DW-1:0] out_q[$];
  int src_idx, pops, wr_cnt, go_cyc;
  int first_rd_cyc, first_wr_cyc, last_wr_cyc;
  int rd_stall, wr_stall;

  // Reference transform: each 32-bit lane handled on its own.
  function automatic logic [DW-1:0] model(input logic [DW-1:0] line, input int md,
                                          input logic [LW-1:0] op);
    logic [DW-1:0] res;
    logic [LW-1:0] x, y;
    res = '0;
    for (int l = 0; l < NL; l++) begin
      x = line[l*LW +: LW];
      case (md)
        1: y = LW'(x + op);
        2: y = x ^ op;
        3: for (int b = 0; b < 4; b++) y[8*b +: 8] = x[8*(3-b) +: 8];
        default: y = x;
      endcase
      res[l*LW +: LW] = y;
    end
    return res;
  endfunction

  // fill: 0 random, 1 all ones, 2 every lane 0x11223344
  function automatic logic [DW-1:0] make_line(input int fill);
    logic [DW-1:0] v;
    for (int l = 0; l < NL; l++) begin
      case (fill)
        1: v[l*LW +: LW] = 32'hFFFF_FFFF;
        2: v[l*LW +: LW] = 32'h1122_3344;
        default: v[l*LW +: LW] = $urandom();
      endcase
    end
    return v;
  endfunction

  // One clock: drive FIFO-side inputs, sample just after, advance to next negedge.
  task automatic step();
    rd_empty = (src_idx >= src_q.size()) || ($urandom_range(99) < rd_stall);
    rd_data  = (src_idx < src_q.size()) ? src_q[src_idx] : '0;
    wr_full  = ($urandom_range(99) < wr_stall);
    #1;
    if (rd_en) begin
      if (first_rd_cyc < 0) first_rd_cyc = cyc;
      pops++;
      src_idx++;
    end
    if (wr_en) begin
      if (first_wr_cyc < 0) first_wr_cyc = cyc;
      last_wr_cyc = cyc;
      out_q.push_back(wr_data);
      wr_cnt++;
    end
    @(negedge clk);
  endtask

  // Loads size+2 source lines (the extras expose any over-read) and pulses go.
  task automatic start_job(input int n, input int md, input logic [LW-1:0] op, input int fill);
    src_q.delete();
    out_q.delete();
    src_idx = 0; pops = 0; wr_cnt = 0;
    first_rd_cyc = -1; first_wr_cyc = -1; last_wr_cyc = -1;
    for (int i = 0; i < n + 2; i++) src_q.push_back(make_line(fill));
    size = SW'(n); mode = 2'(md); operand = op;
    go = 1'b1;
    go_cyc = cyc;
    step();
    go = 1'b0;
  endtask

  task automatic run_writes(input int n, input int budget);
    int k = 0;
    while (wr_cnt < n && k < budget) begin
      step();
      k++;
    end
  endtask

  task automatic finish_job(input int budget);
    int k = 0;
    wr_done = 1'b1;
    while (!done && k < budget) begin
      step();
      k++;
    end
    wr_done = 1'b0;
  endtask

  task automatic test_reset();
    rd_empty = 1'b0;
    #1;
    n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %0b want 0", busy); else n_pass++;
    n_checks++; if (done !== 1'b0) $display("FAIL reset_done: got %0b want 0", done); else n_pass++;
    n_checks++; if (rd_en !== 1'b0) $display("FAIL reset_rd_en: got %0b want 0", rd_en); else n_pass++;
    n_checks++; if (wr_en !== 1'b0) $display("FAIL reset_wr_en: got %0b want 0", wr_en); else n_pass++;
    n_checks++; if (lines_out !== '0) $display("FAIL reset_lines_out: got %0d want 0", lines_out); else n_pass++;
    n_checks++; if (wr_data !== '0) $display("FAIL reset_wr_data: got %h want 0", wr_data); else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_pass();
    logic [DW-1:0] exp;
    rd_stall = 0; wr_stall = 0;
    start_job(8, 0, '0, 0);
    n_checks++; if (busy !== 1'b1) $display("FAIL pass_busy_t1: got %0b want 1", busy); else n_pass++;
    run_writes(8, 60);
    n_checks++; if (first_rd_cyc !== go_cyc + 1) $display("FAIL pass_first_rd: got %0d want %0d", first_rd_cyc, go_cyc + 1); else n_pass++;
    n_checks++; if (first_wr_cyc !== go_cyc + 3) $display("FAIL pass_first_wr: got %0d want %0d", first_wr_cyc, go_cyc + 3); else n_pass++;
    n_checks++; if (last_wr_cyc !== go_cyc + 10) $display("FAIL pass_last_wr: got %0d want %0d", last_wr_cyc, go_cyc + 10); else n_pass++;
    for (int i = 0; i < 8; i++) begin
      exp = src_q[i];
      n_checks++;
      if (i >= out_q.size() || out_q[i] !== exp)
        $display("FAIL pass_line%0d: got %h want %h", i, (i < out_q.size()) ? out_q[i] : {DW{1'bx}}, exp);
      else n_pass++;
    end
    n_checks++; if (done !== 1'b0) $display("FAIL pass_done_early: got %0b want 0", done); else n_pass++;
    finish_job(20);
    n_checks++; if (done !== 1'b1) $display("FAIL pass_done: got %0b want 1", done); else n_pass++;
    n_checks++; if (lines_out !== SW'(8)) $display("FAIL pass_lines_out: got %0d want 8", lines_out); else n_pass++;
    n_checks++; if (pops !== 8) $display("FAIL pass_pops: got %0d want 8", pops); else n_pass++;
  endtask

  task automatic test_lanes();
    logic [DW-1:0] exp_bs;
    exp_bs = {NL{32'h4433_2211}};
    rd_stall = 0; wr_stall = 0;
    start_job(2, 1, 32'h1, 1);
    run_writes(2, 30);
    for (int i = 0; i < 2; i++) begin
      n_checks++;
      if (i >= out_q.size() || out_q[i] !== '0)
        $display("FAIL add_wrap_line%0d: got %h want 0", i, (i < out_q.size()) ? out_q[i] : {DW{1'bx}});
      else n_pass++;
    end
    finish_job(20);
    start_job(2, 3, $urandom(), 2);
    run_writes(2, 30);
    for (int i = 0; i < 2; i++) begin
      n_checks++;
      if (i >= out_q.size() || out_q[i] !== exp_bs)
        $display("FAIL bswap_line%0d: got %h want %h", i, (i < out_q.size()) ? out_q[i] : {DW{1'bx}}, exp_bs);
      else n_pass++;
    end
    finish_job(20);
  endtask

  task automatic test_random_stress();
    logic [DW-1:0] exp;
    logic [LW-1:0] op;
    op = 32'hA5A5_A5A5;
    rd_stall = 30; wr_stall = 40;
    start_job(100, 2, op, 0);
    run_writes(100, 3000);
    repeat (5) step();
    n_checks++; if (wr_cnt !== 100) $display("FAIL stress_wr_count: got %0d want 100", wr_cnt); else n_pass++;
    n_checks++; if (pops !== 100) $display("FAIL stress_pops: got %0d want 100", pops); else n_pass++;
    n_checks++; if (lines_out !== SW'(100)) $display("FAIL stress_lines_out: got %0d want 100", lines_out); else n_pass++;
    for (int i = 0; i < 100; i++) begin
      exp = model(src_q[i], 2, op);
      n_checks++;
      if (i >= out_q.size() || out_q[i] !== exp)
        $display("FAIL stress_line%0d: got %h want %h", i, (i < out_q.size()) ? out_q[i] : {DW{1'bx}}, exp);
      else n_pass++;
    end
    finish_job(20);
    n_checks++; if (done !== 1'b1) $display("FAIL stress_done: got %0b want 1", done); else n_pass++;
    rd_stall = 0; wr_stall = 0;
  endtask

  task automatic test_size_zero_and_ignored_go();
    logic [DW-1:0] exp;
    rd_stall = 0; wr_stall = 0;
    start_job(0, 0, '0, 0);
    n_checks++; if (done !== 1'b1) $display("FAIL zero_done_t1: got %0b want 1", done); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL zero_busy: got %0b want 0", busy); else n_pass++;
    repeat (3) step();
    n_checks++; if (pops !== 0) $display("FAIL zero_no_rd: got %0d pops want 0", pops); else n_pass++;
    n_checks++; if (lines_out !== '0) $display("FAIL zero_lines_out: got %0d want 0", lines_out); else n_pass++;

    wr_stall = 60;
    start_job(5, 0, '0, 0);
    repeat (3) step();
    go = 1'b1; size = SW'(3); mode = 2'd2; operand = $urandom();
    step();
    go = 1'b0;
    run_writes(5, 400);
    wr_stall = 0;
    repeat (3) step();
    n_checks++; if (wr_cnt !== 5) $display("FAIL ignored_go_wr_count: got %0d want 5", wr_cnt); else n_pass++;
    n_checks++; if (lines_out !== SW'(5)) $display("FAIL ignored_go_lines_out: got %0d want 5", lines_out); else n_pass++;
    for (int i = 0; i < 5; i++) begin
      exp = model(src_q[i], 0, '0);
      n_checks++;
      if (i >= out_q.size() || out_q[i] !== exp)
        $display("FAIL ignored_go_line%0d: got %h want %h", i, (i < out_q.size()) ? out_q[i] : {DW{1'bx}}, exp);
      else n_pass++;
    end
    finish_job(20);
    n_checks++; if (done !== 1'b1) $display("FAIL ignored_go_done: got %0b want 1", done); else n_pass++;
  endtask

  task automatic test_reset_mid_job();
    logic [DW-1:0] exp;
    logic [LW-1:0] op;
    rd_stall = 0; wr_stall = 100;
    start_job(20, 1, $urandom(), 0);
    repeat (6) step();
    n_checks++; if (pops !== 2) $display("FAIL stall_fill_pops: got %0d want 2", pops); else n_pass++;
    n_checks++; if (wr_cnt !== 0) $display("FAIL stall_no_wr: got %0d want 0", wr_cnt); else n_pass++;
    rst = 1'b1;
    step();
    #1;
    n_checks++; if (busy !== 1'b0) $display("FAIL midrst_busy: got %0b want 0", busy); else n_pass++;
    n_checks++; if (done !== 1'b0) $display("FAIL midrst_done: got %0b want 0", done); else n_pass++;
    n_checks++; if (rd_en !== 1'b0) $display("FAIL midrst_rd_en: got %0b want 0", rd_en); else n_pass++;
    n_checks++; if (lines_out !== '0) $display("FAIL midrst_lines_out: got %0d want 0", lines_out); else n_pass++;
    n_checks++; if (wr_data !== '0) $display("FAIL midrst_wr_data: got %h want 0", wr_data); else n_pass++;
    wr_full = 1'b0;
    #1;
    n_checks++; if (wr_en !== 1'b0) $display("FAIL midrst_wr_en: got %0b want 0", wr_en); else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    wr_stall = 0;
    op = $urandom();
    start_job(2, 2, op, 0);
    run_writes(2, 30);
    for (int i = 0; i < 2; i++) begin
      exp = model(src_q[i], 2, op);
      n_checks++;
      if (i >= out_q.size() || out_q[i] !== exp)
        $display("FAIL postrst_line%0d: got %h want %h", i, (i < out_q.size()) ? out_q[i] : {DW{1'bx}}, exp);
      else n_pass++;
    end
    finish_job(20);
    n_checks++; if (done !== 1'b1) $display("FAIL postrst_done: got %0b want 1", done); else n_pass++;
    n_checks++; if (lines_out !== SW'(2)) $display("FAIL postrst_lines_out: got %0d want 2", lines_out); else n_pass++;
  endtask

  task automatic test_wr_done_delay();
    int viol;
    rd_stall = 0; wr_stall = 0;
    start_job(4, 3, $urandom(), 0);
    run_writes(4, 30);
    viol = 0;
    for (int i = 0; i < 20; i++) begin
      if (busy !== 1'b1 || done !== 1'b0) viol++;
      step();
    end
    n_checks++; if (viol !== 0) $display("FAIL wait_wr_hold: got %0d bad cycles want 0", viol); else n_pass++;
    n_checks++; if (busy !== 1'b1) $display("FAIL wait_wr_busy: got %0b want 1", busy); else n_pass++;
    wr_done = 1'b1;
    step();
    wr_done = 1'b0;
    n_checks++; if (done !== 1'b1) $display("FAIL wait_wr_done_rise: got %0b want 1", done); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL wait_wr_busy_drop: got %0b want 0", busy); else n_pass++;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; go = 1'b0; wr_done = 1'b0;
    size = '0; mode = '0; operand = '0;
    rd_empty = 1'b1; rd_data = '0; wr_full = 1'b0;
    rd_stall = 0; wr_stall = 0;
    src_idx = 0; pops = 0; wr_cnt = 0; go_cyc = 0;
    first_rd_cyc = -1; first_wr_cyc = -1; last_wr_cyc = -1;
    repeat (3) @(negedge clk);
    test_reset();
    rst = 1'b0;
    @(negedge clk);
    test_pass();
    test_lanes();
    test_random_stress();
    test_size_zero_and_ignored_go();
    test_reset_mid_job();
    test_wr_done_delay();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
